mcu_spi_target: RTL and testbench

- SPI target (mode 0, MSB first) that receives the byte stream the MCU sends to the FPGA and returns reply bytes to it.
- It deserializes each frame into a command byte plus payload bytes. Payload bytes are routed as start/strobe/data handshakes to the SYS, HID, OSD and SDC consumers, for example the osd_u8g2 data_in_start/data_in_strobe/data_in port.
- It is the MCU-facing end of the strobe/byte interface that the video path consumes. It sits in the clk32 domain next to video.

---
 rtl/mcu_spi_pkg.sv | 24 ++
 rtl/spi_sync_edge.sv | 34 +++
 rtl/mcu_spi_target.sv | 171 +++++++++++++++++
 tb/tb_mcu_spi_target.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_spi_pkg.sv
// Shared constants for the MCU-to-FPGA SPI link; the command codes match the
// MCU firmware header.
package mcu_spi_pkg;

    localparam logic [7:0] CMD_SYS = 8'd1;
    localparam logic [7:0] CMD_HID = 8'd2;
    localparam logic [7:0] CMD_OSD = 8'd3;
    localparam logic [7:0] CMD_SDC = 8'd4;

    typedef enum logic [1:0] {IDLE, CMD, PAYLOAD} spi_state_t;

    typedef enum logic [2:0] {TGT_NONE, TGT_SYS, TGT_HID, TGT_OSD, TGT_SDC} target_t;

    function automatic target_t decode_target(input logic [7:0] cmd);
        case (cmd)
            CMD_SYS: return TGT_SYS;
            CMD_HID: return TGT_HID;
            CMD_OSD: return TGT_OSD;
            CMD_SDC: return TGT_SDC;
            default: return TGT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous SPI line, with registered
// one-cycle rise/fall pulses on the synchronized level.
module spi_sync_edge #(
    parameter int   STAGES     = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= {STAGES{IDLE_LEVEL}};
            prev  <= IDLE_LEVEL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
            rise  <= chain[STAGES-1] & ~prev;
            fall  <= ~chain[STAGES-1] & prev;
        end
    end

    assign level = chain[STAGES-1];

endmodule

// File: rtl/mcu_spi_target.sv
// SPI mode-0 target: command byte selects a consumer, payload bytes are
// strobed out to it, and the consumer's reply byte is shifted back one byte late.
module mcu_spi_target
    import mcu_spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_REPLY  = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_clk,
    input  logic       spi_ss_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       mcu_start,
    output logic [7:0] mcu_data,
    output logic       mcu_sys_strobe,
    output logic       mcu_hid_strobe,
    output logic       mcu_osd_strobe,
    output logic       mcu_sdc_strobe,
    input  logic [7:0] sys_din,
    input  logic [7:0] hid_din,
    input  logic [7:0] osd_din,
    input  logic [7:0] sdc_din,
    output spi_state_t dbg_state,
    output logic [2:0] dbg_bit_cnt
);

    logic sck_level, sck_rise, sck_fall;
    logic ss_level, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic mosi_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sck (
        .clk(clk), .reset(reset), .din(spi_clk),
        .level(sck_level), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_ss (
        .clk(clk), .reset(reset), .din(spi_ss_n),
        .level(ss_level), .rise(ss_rise), .fall(ss_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) mosi_sync <= '0;
        else       mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    end
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // The ss_n chain restarts at the idle level after reset, so a select line
    // already low would look like a fresh falling edge. Only arm once the
    // chain carries real samples and shows ss_n high.
    logic [1:0] warm_cnt;
    logic       ss_armed;

    always_ff @(posedge clk) begin
        if (reset) begin
            warm_cnt <= 2'd0;
            ss_armed <= 1'b0;
        end else if (warm_cnt != 2'(SYNC_STAGES)) begin
            warm_cnt <= warm_cnt + 2'd1;
        end else if (ss_level) begin
            ss_armed <= 1'b1;
        end
    end

    spi_state_t state, state_n;
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] tx_shift;
    logic [7:0] rx_byte;
    logic [7:0] reply_byte;
    target_t    target, cmd_target, reply_target;
    logic       first_pending;
    logic       active;
    logic       byte_done;

    always_comb begin
        active       = (state != IDLE) && !ss_level && !ss_rise;
        byte_done    = active && sck_rise && (bit_cnt == 3'd7);
        rx_byte      = {rx_shift, mosi_s};
        cmd_target   = decode_target(rx_byte);
        reply_target = (state == CMD) ? cmd_target : target;
        reply_byte   = IDLE_REPLY;
        case (reply_target)
            TGT_SYS: reply_byte = sys_din;
            TGT_HID: reply_byte = hid_din;
            TGT_OSD: reply_byte = osd_din;
            TGT_SDC: reply_byte = sdc_din;
            default: reply_byte = IDLE_REPLY;
        endcase
    end

    always_comb begin
        state_n = state;
        if (ss_rise) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:    if (ss_fall && ss_armed) state_n = CMD;
                CMD:     if (byte_done) state_n = PAYLOAD;
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt        <= 3'd0;
            rx_shift       <= 7'd0;
            tx_shift       <= 8'd0;
            target         <= TGT_NONE;
            first_pending  <= 1'b0;
            mcu_data       <= 8'h00;
            mcu_start      <= 1'b0;
            mcu_sys_strobe <= 1'b0;
            mcu_hid_strobe <= 1'b0;
            mcu_osd_strobe <= 1'b0;
            mcu_sdc_strobe <= 1'b0;
        end else begin
            mcu_start      <= 1'b0;
            mcu_sys_strobe <= 1'b0;
            mcu_hid_strobe <= 1'b0;
            mcu_osd_strobe <= 1'b0;
            mcu_sdc_strobe <= 1'b0;
            if (state == IDLE) begin
                bit_cnt <= 3'd0;
                if (ss_fall && ss_armed) begin
                    tx_shift      <= IDLE_REPLY;
                    target        <= TGT_NONE;
                    first_pending <= 1'b1;
                end
            end else if (ss_rise) begin
                bit_cnt <= 3'd0;
            end else if (active && sck_rise) begin
                rx_shift <= rx_byte[6:0];
                bit_cnt  <= bit_cnt + 3'd1;
                if (byte_done) begin
                    tx_shift <= reply_byte;
                    if (state == CMD) begin
                        target <= cmd_target;
                    end else if (target != TGT_NONE) begin
                        mcu_data      <= rx_byte;
                        mcu_start     <= first_pending;
                        first_pending <= 1'b0;
                        case (target)
                            TGT_SYS: mcu_sys_strobe <= 1'b1;
                            TGT_HID: mcu_hid_strobe <= 1'b1;
                            TGT_OSD: mcu_osd_strobe <= 1'b1;
                            TGT_SDC: mcu_sdc_strobe <= 1'b1;
                            default: ;
                        endcase
                    end
                end
            // The fall after a byte's last bit must keep the freshly loaded bit 7.
            end else if (active && sck_fall && (bit_cnt != 3'd0)) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
        end
    end

    assign spi_miso    = ((state != IDLE) && !ss_level) ? tx_shift[7] : 1'b0;
    assign dbg_state   = state;
    assign dbg_bit_cnt = bit_cnt;

endmodule

// File: tb/tb_mcu_spi_target.sv
// Directed bench for mcu_spi_target: drives SPI frames from the MCU side and
// checks strobes, payload data, reply bytes and edge cases.
module tb_mcu_spi_target;
    import mcu_spi_pkg::*;

    localparam int SYNC_STAGES = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       spi_clk = 1'b0;
    logic       spi_ss_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       mcu_start;
    logic [7:0] mcu_data;
    logic       mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe, mcu_sdc_strobe;
    logic [7:0] sys_din = 8'h00, hid_din = 8'h00, osd_din = 8'h00, sdc_din = 8'h00;
    spi_state_t dbg_state;
    logic [2:0] dbg_bit_cnt;

    mcu_spi_target #(.SYNC_STAGES(SYNC_STAGES), .IDLE_REPLY(8'h00)) dut (
        .clk(clk), .reset(reset),
        .spi_clk(spi_clk), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .mcu_start(mcu_start), .mcu_data(mcu_data),
        .mcu_sys_strobe(mcu_sys_strobe), .mcu_hid_strobe(mcu_hid_strobe),
        .mcu_osd_strobe(mcu_osd_strobe), .mcu_sdc_strobe(mcu_sdc_strobe),
        .sys_din(sys_din), .hid_din(hid_din), .osd_din(osd_din), .sdc_din(sdc_din),
        .dbg_state(dbg_state), .dbg_bit_cnt(dbg_bit_cnt)
    );

    // ---- clock / cycle counter ----
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    logic [12:0] obs_q[$];
    logic [12:0] exp_q[$];
    int   last8_cyc = 0;
    logic prev_any = 1'b0;
    logic [3:0] stb;

    // ---- scoreboard monitor: events {sys,hid,osd,sdc, start, data} ----
    always @(negedge clk) begin
        stb = {mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe, mcu_sdc_strobe};
        if (stb != 4'b0000 || mcu_start === 1'b1) begin
            obs_q.push_back({stb, mcu_start, mcu_data});
            checks++;
            if (cyc - (last8_cyc + 1) != SYNC_STAGES + 1) begin
                failures++;
                $display("FAIL strobe_delay got=%0d exp=%0d", cyc - (last8_cyc + 1), SYNC_STAGES + 1);
            end
            checks++;
            if (prev_any !== 1'b0) begin
                failures++;
                $display("FAIL strobe_width got=2+ cycles exp=1 cycle");
            end
        end
        prev_any = |stb;
    end

    // ---- driver tasks ----
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nbits, input int half, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = b[i];
            tick(half);
            rx[i] = spi_miso;
            spi_clk = 1'b1;
            if (i == 0) last8_cyc = cyc;
            tick(half);
            spi_clk = 1'b0;
        end
    endtask

    task automatic spi_select();
        spi_ss_n = 1'b0;
        tick(8);
    endtask

    task automatic spi_deselect();
        tick(4);
        spi_ss_n = 1'b1;
        tick(8);
    endtask

    // ---- tests ----
    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        checks++; if ({mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe, mcu_sdc_strobe, mcu_start} !== 5'b0) begin
            failures++; $display("FAIL reset_strobes got=%b exp=00000",
                {mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe, mcu_sdc_strobe, mcu_start}); end
        checks++; if (mcu_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", mcu_data); end
        checks++; if (spi_miso !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b exp=0", spi_miso); end
        checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
        checks++; if (dbg_bit_cnt !== 3'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", dbg_bit_cnt); end
        tick(8);
    endtask

    task automatic test_osd_frame();
        logic [7:0] rx;
        obs_q.delete(); exp_q.delete();
        exp_q.push_back({4'b0010, 1'b1, 8'hA5});
        exp_q.push_back({4'b0010, 1'b0, 8'h5A});
        spi_select();
        spi_bits(8'h03, 8, 2, rx);
        spi_bits(8'hA5, 8, 2, rx);
        spi_bits(8'h5A, 8, 2, rx);
        spi_deselect();
        checks++; if (obs_q.size() != exp_q.size()) begin failures++;
            $display("FAIL osd_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++;
                $display("FAIL osd_event%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (mcu_data !== 8'h5A) begin failures++; $display("FAIL osd_hold got=%h exp=5a", mcu_data); end
    endtask

    task automatic test_miso_reply();
        logic [7:0] r0, r1, r2;
        obs_q.delete(); exp_q.delete();
        exp_q.push_back({4'b0010, 1'b1, 8'h11});
        exp_q.push_back({4'b0010, 1'b0, 8'h22});
        osd_din = 8'hC3;
        spi_select();
        spi_bits(8'h03, 8, 6, r0);
        osd_din = 8'h96;
        spi_bits(8'h11, 8, 6, r1);
        osd_din = 8'h5F;
        spi_bits(8'h22, 8, 6, r2);
        spi_deselect();
        checks++; if (r0 !== 8'h00) begin failures++; $display("FAIL miso_byte0 got=%h exp=00", r0); end
        checks++; if (r1 !== 8'hC3) begin failures++; $display("FAIL miso_byte1 got=%h exp=c3", r1); end
        checks++; if (r2 !== 8'h96) begin failures++; $display("FAIL miso_byte2 got=%h exp=96", r2); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++;
            $display("FAIL miso_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++;
                $display("FAIL miso_event%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_unknown_target();
        logic [7:0] r0, r1;
        obs_q.delete();
        sys_din = 8'hFF; hid_din = 8'hFF; osd_din = 8'hFF; sdc_din = 8'hFF;
        spi_select();
        spi_bits(8'h07, 8, 6, r0);
        spi_bits(8'h44, 8, 6, r1);
        spi_deselect();
        checks++; if (r0 !== 8'h00) begin failures++; $display("FAIL unk_miso0 got=%h exp=00", r0); end
        checks++; if (r1 !== 8'h00) begin failures++; $display("FAIL unk_miso1 got=%h exp=00", r1); end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL unk_count got=%0d exp=0", obs_q.size()); end
        checks++; if (mcu_data !== 8'h22) begin failures++; $display("FAIL unk_hold got=%h exp=22", mcu_data); end
    endtask

    task automatic test_abort_mid_byte();
        logic [7:0] rx;
        obs_q.delete(); exp_q.delete();
        exp_q.push_back({4'b0100, 1'b1, 8'h80});
        spi_select();
        spi_bits(8'h02, 8, 2, rx);
        spi_bits(8'h80, 8, 2, rx);
        spi_bits(8'hFF, 5, 2, rx);
        spi_deselect();
        checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL abort_state got=%0d exp=%0d", dbg_state, IDLE); end
        checks++; if (dbg_bit_cnt !== 3'd0) begin failures++; $display("FAIL abort_cnt got=%0d exp=0", dbg_bit_cnt); end
        exp_q.push_back({4'b1000, 1'b1, 8'h3C});
        spi_select();
        spi_bits(8'h01, 8, 2, rx);
        spi_bits(8'h3C, 8, 2, rx);
        spi_deselect();
        checks++; if (obs_q.size() != exp_q.size()) begin failures++;
            $display("FAIL abort_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++;
                $display("FAIL abort_event%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] rx;
        obs_q.delete(); exp_q.delete();
        spi_select();
        spi_bits(8'h04, 8, 2, rx);
        spi_bits(8'hAB, 4, 2, rx);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        spi_bits(8'h12, 8, 2, rx);
        spi_bits(8'h34, 8, 2, rx);
        tick(6);
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL rst_mid_count got=%0d exp=0", obs_q.size()); end
        checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL rst_mid_state got=%0d exp=%0d", dbg_state, IDLE); end
        checks++; if (mcu_data !== 8'h00) begin failures++; $display("FAIL rst_mid_data got=%h exp=00", mcu_data); end
        spi_deselect();
        exp_q.push_back({4'b0001, 1'b1, 8'hFF});
        spi_select();
        spi_bits(8'h04, 8, 2, rx);
        spi_bits(8'hFF, 8, 2, rx);
        spi_deselect();
        checks++; if (obs_q.size() != exp_q.size()) begin failures++;
            $display("FAIL rst_mid_frame_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++;
                $display("FAIL rst_mid_event%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_sck_deselected();
        logic [7:0] pattern;
        obs_q.delete();
        pattern = 8'b1011_0110;
        sys_din = 8'hFF; hid_din = 8'hFF; osd_din = 8'hFF; sdc_din = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            spi_mosi = pattern[i % 8];
            tick(2);
            spi_clk = 1'b1;
            tick(2);
            spi_clk = 1'b0;
            checks++; if (spi_miso !== 1'b0) begin failures++; $display("FAIL desel_miso%0d got=%b exp=0", i, spi_miso); end
        end
        tick(6);
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL desel_count got=%0d exp=0", obs_q.size()); end
        checks++; if (dbg_bit_cnt !== 3'd0) begin failures++; $display("FAIL desel_cnt got=%0d exp=0", dbg_bit_cnt); end
        checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL desel_state got=%0d exp=%0d", dbg_state, IDLE); end
    endtask

    initial begin
        test_reset();
        test_osd_frame();
        test_miso_reply();
        test_unknown_target();
        test_abort_mid_byte();
        test_reset_mid_frame();
        test_sck_deselected();
        tick(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
